pic_row_writer: RTL and testbench

//   Writer side of the picture row memory that the CNN front end reads (one
//   224-bit row per address, 28 pixels x 8 bit, 300 rows). Accepts a

---
 rtl/pic_row_writer.sv | 109 ++++++++++
 tb/tb_pic_row_writer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pic_row_writer.sv
// Packs a valid/ready pixel stream into ROW_PIX-pixel row words and writes one row per memory address.
// A row write issues the cycle after its last pixel; ready is held low only by start or outside LOAD.
module pic_row_writer #(
  parameter int PIX_W   = 8,
  parameter int ROW_PIX = 28,
  parameter int DEPTH   = 300,
  parameter int AW      = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PIX_W-1:0]         in_pixel,
  output logic                     wr_en,
  output logic [AW-1:0]            wr_addr,
  output logic [PIX_W*ROW_PIX-1:0] wr_data,
  output logic                     busy,
  output logic                     done
);

  localparam int RW  = PIX_W * ROW_PIX;
  localparam int PCW = $clog2(ROW_PIX);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t          state_q, state_d;
  logic [PCW-1:0]  pix_cnt_q, pix_cnt_d;
  logic [AW-1:0]   row_cnt_q, row_cnt_d;
  logic [RW-1:0]   pack_q, pack_d;
  logic [RW-1:0]   row_merged;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [RW-1:0]   wr_data_q, wr_data_d;
  logic            accept;

  assign in_ready = (state_q == LOAD) & ~start;
  assign accept   = in_valid & in_ready;
  assign busy     = (state_q == LOAD);
  assign done     = (state_q == DONE);
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

  // Pack register with the incoming pixel dropped into its slot; first pixel lands in the MSBs.
  always_comb begin
    row_merged = pack_q;
    for (int k = 0; k < ROW_PIX; k++) begin
      if (pix_cnt_q == PCW'(k)) begin
        row_merged[(ROW_PIX-k)*PIX_W-1 -: PIX_W] = in_pixel;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    row_cnt_d = row_cnt_q;
    pack_d    = pack_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (start) begin
      state_d   = LOAD;
      pix_cnt_d = '0;
      row_cnt_d = '0;
      pack_d    = '0;
    end else if (accept) begin
      if (pix_cnt_q == PCW'(ROW_PIX-1)) begin
        wr_en_d   = 1'b1;
        wr_addr_d = row_cnt_q;
        wr_data_d = row_merged;
        pack_d    = '0;
        pix_cnt_d = '0;
        // Last row ends the frame; row_cnt stays at DEPTH-1 rather than wrapping.
        if (row_cnt_q == AW'(DEPTH-1)) begin
          state_d = DONE;
        end else begin
          row_cnt_d = row_cnt_q + AW'(1);
        end
      end else begin
        pack_d    = row_merged;
        pix_cnt_d = pix_cnt_q + PCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pix_cnt_q <= '0;
      row_cnt_q <= '0;
      pack_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      row_cnt_q <= row_cnt_d;
      pack_q    <= pack_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_pic_row_writer.sv
// Bench for pic_row_writer: a frame-level model (queue of accepted pixels) predicts every write.
module tb_pic_row_writer;

  localparam int ROWS = 300;
  localparam int RPIX = 28;
  localparam int FPIX = ROWS * RPIX;

  logic         clk = 1'b0;
  logic         rst, start, in_valid, in_ready;
  logic [7:0]   in_pixel;
  logic         wr_en, busy, done;
  logic [8:0]   wr_addr;
  logic [223:0] wr_data;

  int total = 0;
  int bad   = 0;

  // Model: 0 idle, 1 loading, 2 frame done; frame holds every pixel accepted since the last start.
  int         m_state = 0;
  logic [7:0] frame[$];
  int         dut_writes = 0;

  always #5 clk = ~clk;

  pic_row_writer dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [223:0] act, input logic [223:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, check ready before the edge, check registered outputs after it.
  task automatic step(input logic r, input logic s, input logic v, input logic [7:0] p,
                      output logic obs_rdy);
    logic         exp_rdy, exp_wr;
    logic [8:0]   ea;
    logic [223:0] ed;
    int           n;
    rst = r; start = s; in_valid = v; in_pixel = p;
    #1;
    obs_rdy = in_ready;
    exp_rdy = (m_state == 1) && !s;
    chk("in_ready", {223'd0, in_ready}, {223'd0, exp_rdy});
    exp_wr = 1'b0; ea = '0; ed = '0;
    if (r) begin
      m_state = 0; frame.delete();
    end else if (s) begin
      m_state = 1; frame.delete();
    end else if (exp_rdy && v) begin
      frame.push_back(p);
      n = frame.size();
      if (n % RPIX == 0) begin
        exp_wr = 1'b1;
        ea = 9'(n / RPIX - 1);
        for (int k = 0; k < RPIX; k++) ed = {ed[215:0], frame[n-RPIX+k]};
        if (n == FPIX) m_state = 2;
      end
    end
    @(posedge clk);
    #1;
    if (wr_en === 1'b1) dut_writes++;
    chk("wr_en", {223'd0, wr_en}, {223'd0, exp_wr});
    chk("busy",  {223'd0, busy},  {223'd0, (m_state == 1)});
    chk("done",  {223'd0, done},  {223'd0, (m_state == 2)});
    if (exp_wr) begin
      chk("wr_addr", {215'd0, wr_addr}, {215'd0, ea});
      chk("wr_data", wr_data, ed);
    end
    if (r) begin
      chk("rst_addr", {215'd0, wr_addr}, '0);
      chk("rst_data", wr_data, '0);
    end
  endtask

  typedef struct {
    logic       r, s, v;
    logic [7:0] p;
    logic       e_rdy, e_busy, e_done;
  } vec_t;

  vec_t tbl[7];
  logic rdy;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_pixel = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      step(tbl[i].r, tbl[i].s, tbl[i].v, tbl[i].p, rdy);
      chk($sformatf("tbl%0d_rdy", i),  {223'd0, rdy},  {223'd0, tbl[i].e_rdy});
      chk($sformatf("tbl%0d_busy", i), {223'd0, busy}, {223'd0, tbl[i].e_busy});
      chk($sformatf("tbl%0d_done", i), {223'd0, done}, {223'd0, tbl[i].e_done});
    end

    // Single row right after a start+valid cycle: pixel 0x55 must not have been counted.
    for (int i = 1; i <= RPIX; i++) step(1'b0, 1'b0, 1'b1, 8'(i), rdy);
    chk("row_wr_en", {223'd0, wr_en}, 224'd1);
    chk("row_addr",  {215'd0, wr_addr}, 224'd0);
    chk("row_msb",   {216'd0, wr_data[223:216]}, 224'h01);
    chk("row_lsb",   {216'd0, wr_data[7:0]}, 224'h1C);
    step(1'b0, 1'b0, 1'b0, 8'h00, rdy);
    chk("row_single", {223'd0, wr_en}, 224'd0);

    // Restart mid-row: partial row discarded, new frame starts at address 0.
    step(1'b0, 1'b1, 1'b0, 8'h00, rdy);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 8'(8'h30 + i), rdy);
    step(1'b0, 1'b1, 1'b0, 8'h00, rdy);
    dut_writes = 0;
    for (int i = 0; i < RPIX; i++) step(1'b0, 1'b0, 1'b1, 8'hAA, rdy);
    chk("restart_addr", {215'd0, wr_addr}, 224'd0);
    chk("restart_data", wr_data, {28{8'hAA}});
    chk("restart_nwr", 224'(dut_writes), 224'd1);

    // Reset after row 5 has been written.
    step(1'b0, 1'b1, 1'b0, 8'h00, rdy);
    for (int i = 0; i < 6 * RPIX; i++) step(1'b0, 1'b0, 1'b1, 8'($urandom), rdy);
    step(1'b1, 1'b0, 1'b1, 8'h77, rdy);
    chk("midrst_busy", {223'd0, busy}, 224'd0);
    step(1'b0, 1'b0, 1'b1, 8'h77, rdy);
    step(1'b0, 1'b1, 1'b0, 8'h00, rdy);
    for (int i = 0; i < RPIX; i++) step(1'b0, 1'b0, 1'b1, 8'($urandom), rdy);
    chk("midrst_addr", {215'd0, wr_addr}, 224'd0);

    // Full frame with random valid gaps.
    step(1'b0, 1'b1, 1'b0, 8'h00, rdy);
    dut_writes = 0;
    for (int i = 0; i < 30000 && m_state == 1; i++)
      step(1'b0, 1'b0, ($urandom_range(0, 3) != 0), 8'($urandom), rdy);
    chk("frame_end", 224'(m_state), 224'd2);
    chk("frame_nwr", 224'(dut_writes), 224'(ROWS));
    chk("frame_last_addr", {215'd0, wr_addr}, 224'(ROWS - 1));
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 8'($urandom), rdy);
    chk("frame_no_extra", 224'(dut_writes), 224'(ROWS));
    chk("frame_done_hold", {223'd0, done}, 224'd1);

    // Start in DONE releases done and opens a new frame.
    step(1'b0, 1'b1, 1'b1, 8'h00, rdy);
    chk("restart_done", {223'd0, done}, 224'd0);
    step(1'b0, 1'b0, 1'b1, 8'h09, rdy);
    chk("restart_rdy", {223'd0, rdy}, 224'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
